// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared widths, entry layout and FSM encodings for the BTB write sequencer
// Purpose: constants, the queued-update record type and the entry-packing helper
//          used by btb_ctrl, btb_ctrl_if and btb_upd_fifo.
// Ports:   none (package).
package btb_pkg;

  localparam int PC_W    = 13;
  localparam int IDX_W   = 11;
  localparam int TAG_W   = 2;
  localparam int ENTRY_W = 16;

  // Entry layout: {valid, tag[1:0], target[12:0]}
  localparam int ENT_VALID_BIT = 15;
  localparam int ENT_TAG_LSB   = 13;
  localparam int ENT_TGT_LSB   = 0;

  localparam int UPD_W = IDX_W + ENTRY_W;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [ENTRY_W-1:0] entry;
  } upd_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [PC_W-1:0] pc,
                                                    input logic [PC_W-1:0] tgt);
    return {1'b1, pc[PC_W-1 -: TAG_W], tgt};
  endfunction

endpackage

// File: rtl/btb_ctrl_if.sv
// rtl/btb_ctrl_if.sv - pipeline/table-side signal bundle of the BTB write sequencer
// Purpose: groups update, flush, lookup-perf inputs and table write outputs.
// Ports (signals): upd_d_*/upd_e_* mispredict updates, flush_req, lookup_valid,
//          hit_predict in; busy, wen, w_addr, w_data, drop_cnt out.
//          With BTB_PERF_CNT_EN defined also perf_lookup, perf_hit, perf_upd out.
// Modports: master = pipeline side, slave = btb_ctrl.
interface btb_ctrl_if;
  import btb_pkg::*;

  logic               upd_d_valid;
  logic [PC_W-1:0]    upd_d_pc;
  logic [PC_W-1:0]    upd_d_target;
  logic               upd_e_valid;
  logic [PC_W-1:0]    upd_e_pc;
  logic [PC_W-1:0]    upd_e_target;
  logic               flush_req;
  logic               lookup_valid;
  logic               hit_predict;
  logic               busy;
  logic               wen;
  logic [IDX_W-1:0]   w_addr;
  logic [ENTRY_W-1:0] w_data;
  logic [7:0]         drop_cnt;
`ifdef BTB_PERF_CNT_EN
  logic [31:0]        perf_lookup;
  logic [31:0]        perf_hit;
  logic [31:0]        perf_upd;
`endif

  modport master (
    output upd_d_valid, upd_d_pc, upd_d_target,
    output upd_e_valid, upd_e_pc, upd_e_target,
    output flush_req, lookup_valid, hit_predict,
`ifdef BTB_PERF_CNT_EN
    input  perf_lookup, perf_hit, perf_upd,
`endif
    input  busy, wen, w_addr, w_data, drop_cnt
  );

  modport slave (
    input  upd_d_valid, upd_d_pc, upd_d_target,
    input  upd_e_valid, upd_e_pc, upd_e_target,
    input  flush_req, lookup_valid, hit_predict,
`ifdef BTB_PERF_CNT_EN
    output perf_lookup, perf_hit, perf_upd,
`endif
    output busy, wen, w_addr, w_data, drop_cnt
  );

endinterface

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - small synchronous FIFO holding pending BTB updates
// Purpose: DEPTH-entry FIFO; push and pop may coincide, including when full.
// Ports: clk, rst (sync, active high), push, pop, wdata in;
//        rdata (head), full, empty, count out.
//        The caller must not push when full unless it pops in the same cycle.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  upd_t                     wdata,
  output upd_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  upd_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/btb_ctrl.sv
// rtl/btb_ctrl.sv - write-port sequencer for the 2048-entry direct-mapped BTB
// Purpose: sweeps the table to zero after reset and on flush_req, arbitrates
//          D/E mispredict updates (E wins), queues updates arriving during a
//          sweep and drains them afterwards; drives wen/w_addr/w_data and busy.
// Ports: clk, rst (sync, active high); bus (btb_ctrl_if.slave) carrying the
//        update/flush/lookup inputs and busy/wen/w_addr/w_data/drop_cnt outputs.
// Config: BTB_PERF_CNT_EN adds perf_lookup/perf_hit/perf_upd wrapping counters.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int UPD_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  btb_ctrl_if.slave  bus
);
  localparam int CW = $clog2(UPD_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  logic [1:0]       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]       drop_q;

  logic             sel_valid;
  upd_t             sel;
  upd_t             head;
  logic             q_full, q_empty;
  logic [CW:0]      q_count;
  logic             push_req, push_ok, pop, drop;

  logic             wen;
  logic [IDX_W-1:0] w_addr;
  logic [ENTRY_W-1:0] w_data;
  logic             busy;

  // E-stage mispredict is older in program order, so any D update is on the wrong path.
  assign sel_valid = bus.upd_e_valid | bus.upd_d_valid;
  assign sel.idx   = bus.upd_e_valid ? bus.upd_e_pc[IDX_W-1:0] : bus.upd_d_pc[IDX_W-1:0];
  assign sel.entry = bus.upd_e_valid ? make_entry(bus.upd_e_pc, bus.upd_e_target)
                                     : make_entry(bus.upd_d_pc, bus.upd_d_target);

  // Updates are queued whenever a direct write is not possible: during a sweep,
  // while draining (to keep FIFO order), or when a flush is about to start one.
  assign push_req = !rst && sel_valid &&
                    ((state != ST_IDLE) || bus.flush_req);
  // A flush in DRAIN holds the head so it is retired after the new sweep.
  assign pop      = !rst && (state == ST_DRAIN) && !bus.flush_req;
  assign push_ok  = push_req && (!q_full || pop);
  assign drop     = push_req && !push_ok;

  btb_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .wdata (sel),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    wen     = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    busy    = 1'b0;
    if (!rst) begin
      case (state)
        ST_CLEAR: begin
          busy   = 1'b1;
          wen    = 1'b1;
          w_addr = idx;
          idx_n  = idx + 1'b1;
          if (idx == IDX_LAST)
            state_n = (!q_empty || push_ok) ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (pop) begin
            wen    = 1'b1;
            w_addr = head.idx;
            w_data = head.entry;
            if ((q_count == 1) && !push_ok) state_n = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!bus.flush_req && sel_valid) begin
            wen    = 1'b1;
            w_addr = sel.idx;
            w_data = sel.entry;
          end
        end
        default: state_n = ST_CLEAR;
      endcase
      if (bus.flush_req) begin
        state_n = ST_CLEAR;
        idx_n   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_CLEAR;
      idx    <= '0;
      drop_q <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.busy     = busy;
  assign bus.wen      = wen;
  assign bus.w_addr   = w_addr;
  assign bus.w_data   = w_data;
  assign bus.drop_cnt = drop_q;

`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_lookup_q, perf_hit_q, perf_upd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lookup_q <= '0;
      perf_hit_q    <= '0;
      perf_upd_q    <= '0;
    end else begin
      if (bus.lookup_valid && !busy)                    perf_lookup_q <= perf_lookup_q + 32'd1;
      if (bus.lookup_valid && bus.hit_predict && !busy) perf_hit_q    <= perf_hit_q + 32'd1;
      if (wen && (state != ST_CLEAR))                   perf_upd_q    <= perf_upd_q + 32'd1;
    end
  end

  assign bus.perf_lookup = perf_lookup_q;
  assign bus.perf_hit    = perf_hit_q;
  assign bus.perf_upd    = perf_upd_q;
`endif

endmodule

// File: tb/tb_btb_ctrl.sv
// tb/tb_btb_ctrl.sv - self-checking bench for btb_ctrl
module tb_btb_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  btb_ctrl_if bus ();

  btb_ctrl #(.UPD_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int passed = 0;

  typedef struct {
    logic        dv;
    logic [12:0] dpc;
    logic [12:0] dtgt;
    logic        ev;
    logic [12:0] epc;
    logic [12:0] etgt;
    logic        ewen;
    logic [10:0] eaddr;
    logic [15:0] edata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.upd_d_valid  = 1'b0;
    bus.upd_d_pc     = '0;
    bus.upd_d_target = '0;
    bus.upd_e_valid  = 1'b0;
    bus.upd_e_pc     = '0;
    bus.upd_e_target = '0;
    bus.flush_req    = 1'b0;
    bus.lookup_valid = 1'b0;
    bus.hit_predict  = 1'b0;
  endtask

  // Checks n consecutive sweep cycles writing zero to start, start+1, ...
  task automatic sweep(input int start, input int n, inout int bad);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.wen !== 1'b1 || bus.w_addr !== 11'(start + i) ||
          bus.w_data !== 16'h0 || bus.busy !== 1'b1) begin
        if (bad == 0)
          $display("FAIL sweep_cycle: idx %0d got wen=%b addr=%h data=%h busy=%b", start + i,
                   bus.wen, bus.w_addr, bus.w_data, bus.busy);
        bad++;
      end
      next_cycle();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_wen", 32'(bus.wen), 32'h0);
    check("rst_waddr", 32'(bus.w_addr), 32'h0);
    check("rst_wdata", 32'(bus.w_data), 32'h0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic set_d(input logic [12:0] pc, input logic [12:0] tgt);
    bus.upd_d_valid = 1'b1; bus.upd_d_pc = pc; bus.upd_d_target = tgt;
  endtask

  task automatic set_e(input logic [12:0] pc, input logic [12:0] tgt);
    bus.upd_e_valid = 1'b1; bus.upd_e_pc = pc; bus.upd_e_target = tgt;
  endtask

  initial begin
    int bad;
    clear_inputs();
    #1;

    vecs[0] = '{1'b1, 13'h0805, 13'h0100, 1'b0, 13'h0000, 13'h0000, 1'b1, 11'h005, 16'hA100};
    vecs[1] = '{1'b1, 13'h0004, 13'h0003, 1'b1, 13'h1008, 13'h0020, 1'b1, 11'h008, 16'hC020};
    vecs[2] = '{1'b0, 13'h0805, 13'h0100, 1'b0, 13'h1008, 13'h0020, 1'b0, 11'h000, 16'h0000};
    vecs[3] = '{1'b0, 13'h0000, 13'h0000, 1'b1, 13'h1FFF, 13'h1FFF, 1'b1, 11'h7FF, 16'hFFFF};
    vecs[4] = '{1'b1, 13'h0000, 13'h0000, 1'b0, 13'h0000, 13'h0000, 1'b1, 11'h000, 16'h8000};
    vecs[5] = '{1'b0, 13'h0000, 13'h0000, 1'b1, 13'h07FF, 13'h1234, 1'b1, 11'h7FF, 16'h9234};
    vecs[6] = '{1'b1, 13'h1800, 13'h0ABC, 1'b0, 13'h0000, 13'h0000, 1'b1, 11'h000, 16'hEABC};

    // Reset and full power-on sweep
    do_reset();
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
    bad = 0;
    sweep(0, 2048, bad);
    check("init_sweep_errors", 32'(bad), 32'h0);
    @(negedge clk);
    check("post_sweep_wen", 32'(bus.wen), 32'h0);
    check("post_sweep_busy", 32'(bus.busy), 32'h0);
    next_cycle();

`ifdef BTB_PERF_CNT_EN
    for (int i = 0; i < 10; i++) begin
      bus.lookup_valid = 1'b1;
      bus.hit_predict  = (i < 4);
      if (i < 3) set_d(13'(i), 13'h0001);
      next_cycle();
      clear_inputs();
    end
    @(negedge clk);
    check("perf_lookup", bus.perf_lookup, 32'd10);
    check("perf_hit", bus.perf_hit, 32'd4);
    check("perf_upd", bus.perf_upd, 32'd3);
    next_cycle();
`endif

    // Direct writes in IDLE, table-driven
    for (int v = 0; v < 7; v++) begin
      clear_inputs();
      if (vecs[v].dv) set_d(vecs[v].dpc, vecs[v].dtgt);
      if (vecs[v].ev) set_e(vecs[v].epc, vecs[v].etgt);
      @(negedge clk);
      check($sformatf("vec%0d_wen", v), 32'(bus.wen), 32'(vecs[v].ewen));
      check($sformatf("vec%0d_addr", v), 32'(bus.w_addr), 32'(vecs[v].eaddr));
      check($sformatf("vec%0d_data", v), 32'(bus.w_data), 32'(vecs[v].edata));
      check($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'h0);
      next_cycle();
    end
    clear_inputs();

    // Three updates during a sweep with a 2-deep queue: third is dropped
    do_reset();
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      set_e(13'h0010 + 13'(k), 13'h0100 + 13'(k));
      sweep(k, 1, bad);
    end
    clear_inputs();
    sweep(3, 2045, bad);
    check("drop_sweep_errors", 32'(bad), 32'h0);
    @(negedge clk);
    check("drain0_wen", 32'(bus.wen), 32'h1);
    check("drain0_addr", 32'(bus.w_addr), 32'h010);
    check("drain0_data", 32'(bus.w_data), 32'h8100);
    check("drain0_busy", 32'(bus.busy), 32'h0);
    next_cycle();
    @(negedge clk);
    check("drain1_wen", 32'(bus.wen), 32'h1);
    check("drain1_addr", 32'(bus.w_addr), 32'h011);
    check("drain1_data", 32'(bus.w_data), 32'h8101);
    next_cycle();
    @(negedge clk);
    check("drain_done_wen", 32'(bus.wen), 32'h0);
    check("drop_cnt_one", 32'(bus.drop_cnt), 32'h1);
    next_cycle();

    // Flush in IDLE with a coinciding update, then a re-flush mid-sweep
    set_d(13'h0805, 13'h0100);
    bus.flush_req = 1'b1;
    @(negedge clk);
    check("flush_idle_wen", 32'(bus.wen), 32'h0);
    next_cycle();
    clear_inputs();
    bad = 0;
    sweep(0, 1000, bad);
    bus.flush_req = 1'b1;
    sweep(1000, 1, bad);
    clear_inputs();
    sweep(0, 2048, bad);
    check("reflush_sweep_errors", 32'(bad), 32'h0);
    @(negedge clk);
    check("retire_wen", 32'(bus.wen), 32'h1);
    check("retire_addr", 32'(bus.w_addr), 32'h005);
    check("retire_data", 32'(bus.w_data), 32'hA100);
    check("retire_busy", 32'(bus.busy), 32'h0);
    next_cycle();
    @(negedge clk);
    check("retire_done_wen", 32'(bus.wen), 32'h0);
    check("drop_cnt_kept", 32'(bus.drop_cnt), 32'h1);
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
